// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency memory port between two requesters.
//            Port 0 is the CPU datapath (fetch and load/store), port 1 is a
//            secondary master such as DMA or a debug loader. One access runs
//            at a time. Ties are broken round-robin. Memory controls stay
//            stable for the whole access. Read data is registered per port.
//            Each requester gets a one-cycle done pulse.
// Ports    : clk, rst                      - clock, sync active-high reset
//            req0/we0/addr0/wdata0         - port 0 request bundle
//            gnt0/done0/rdata0             - port 0 grant, completion, data
//            req1/we1/addr1/wdata1         - port 1 request bundle
//            gnt1/done1/rdata1             - port 1 grant, completion, data
//            mem_en/mem_we/mem_addr/
//            mem_wdata/mem_rdata           - shared memory port
//            busy                          - arbiter not idle
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              done0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              done1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   // The counter must be at least one bit wide, even when MEM_LAT == 1.
   localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t              state_q,  state_d;
   logic                sel_q,    sel_d;
   logic                we_q,     we_d;
   logic [ADDR_W-1:0]   addr_q,   addr_d;
   logic [DATA_W-1:0]   wdata_q,  wdata_d;
   logic                last_q,   last_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d;
   logic [DATA_W-1:0]   rdata1_q, rdata1_d;
   logic                pick;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      // On a tie, the port that was not served last wins.
      // A lone requester always wins.
      pick     = (req0 && req1) ? ~last_q : req1;

      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               sel_d   = pick;
               we_d    = pick ? we1    : we0;
               addr_d  = pick ? addr1  : addr0;
               wdata_d = pick ? wdata1 : wdata0;
               last_d  = pick;
               cnt_d   = CNT_INIT;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // mem_rdata is valid only in the final access cycle.
               if (!we_q) begin
                  if (sel_q) rdata1_d = mem_rdata;
                  else       rdata0_d = mem_rdata;
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sel_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // All outputs decode from registered state.
   // They never depend on the current inputs.
   assign busy      = (state_q != ST_IDLE);
   assign gnt0      = busy && !sel_q;
   assign gnt1      = busy &&  sel_q;
   assign done0     = (state_q == ST_DONE) && !sel_q;
   assign done1     = (state_q == ST_DONE) &&  sel_q;
   assign mem_en    = (state_q == ST_ACCESS);
   assign mem_we    = (state_q == ST_ACCESS) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter.
//            A MEM_LAT=2 instance is driven through reads, writes, ties,
//            late requests and a mid-access reset.
//            A MEM_LAT=1 instance covers the short-latency build.
//            Expected completions are queued when stimulus is driven.
//            They are popped and compared when a done pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        gnt0, done0, gnt1, done1;
   logic [31:0] rdata0, rdata1;
   logic        mem_en, mem_we, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        b_req0, b_gnt0, b_done0, b_gnt1, b_done1;
   logic        b_mem_en, b_mem_we, b_busy;
   logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
      .clk(clk), .rst(rst),
      .req0(b_req0), .we0(1'b0), .addr0(32'h10), .wdata0(32'h0),
      .gnt0(b_gnt0), .done0(b_done0), .rdata0(b_rdata0),
      .req1(1'b0), .we1(1'b0), .addr1(32'h0), .wdata1(32'h0),
      .gnt1(b_gnt1), .done1(b_done1), .rdata1(b_rdata1),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   // ---------------- memory models ----------------
   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hC0DE0000);
   endfunction

   logic [31:0] mem_arr [0:63];
   logic [63:0] mem_wr = '0;
   int          acc_cnt = 0;

   // Data is presented only in the last access cycle, so early capture reads garbage.
   always @(posedge clk) begin
      acc_cnt <= mem_en ? acc_cnt + 1 : 0;
      if (mem_en && mem_we && acc_cnt == LAT - 1) begin
         mem_arr[mem_addr[7:2]] <= mem_wdata;
         mem_wr[mem_addr[7:2]]  <= 1'b1;
      end
   end

   always_comb begin
      mem_rdata = 32'hBAD0BAD0;
      if (mem_en && !mem_we && acc_cnt == LAT - 1)
         mem_rdata = mem_wr[mem_addr[7:2]] ? mem_arr[mem_addr[7:2]] : init_val(mem_addr);
   end

   assign b_mem_rdata = (b_mem_en && !b_mem_we) ? (b_mem_addr ^ 32'h5A5A5A5A) : 32'hBAD0BAD0;

   // ---------------- scoreboard and bookkeeping ----------------
   typedef struct {
      logic        port;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      bit          timeout;
      logic        port;
      int          cycles;
      int          en_cnt;
      bit          overlap;
      bit          unstable;
      bit          g0;
      bit          g1;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } obs_t;

   exp_t        sb[$];
   exp_t        e;
   obs_t        o;
   logic [31:0] exp_mem [0:63];
   logic [31:0] last_rd [0:1];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic push_rd(input logic p, input logic [31:0] a);
      exp_t x;
      x.port  = p;
      x.rdata = exp_mem[a[7:2]];
      last_rd[p] = x.rdata;
      sb.push_back(x);
   endtask

   task automatic push_wr(input logic p, input logic [31:0] a, input logic [31:0] d);
      exp_t x;
      exp_mem[a[7:2]] = d;
      x.port  = p;
      x.rdata = last_rd[p];
      sb.push_back(x);
   endtask

   task automatic drive(input logic p, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
      else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
   endtask

   task automatic do_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; b_req0 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
   endtask

   // Stimulus-side observer: waits up to max cycles for a done pulse.
   // It records what it saw and makes no comparisons.
   task automatic wait_done(input int max, output obs_t ob);
      ob.timeout = 1'b1; ob.port = 1'b0; ob.cycles = 0; ob.en_cnt = 0;
      ob.overlap = 1'b0; ob.unstable = 1'b0; ob.g0 = 1'b0; ob.g1 = 1'b0;
      ob.addr = '0; ob.we = 1'b0; ob.wdata = '0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         ob.cycles++;
         if (gnt0 && gnt1) ob.overlap = 1'b1;
         if (gnt0) ob.g0 = 1'b1;
         if (gnt1) ob.g1 = 1'b1;
         if (mem_en) begin
            if (ob.en_cnt == 0) begin
               ob.addr = mem_addr; ob.we = mem_we; ob.wdata = mem_wdata;
            end else if (mem_addr !== ob.addr || mem_we !== ob.we || mem_wdata !== ob.wdata) begin
               ob.unstable = 1'b1;
            end
            ob.en_cnt++;
         end
         if (done0 || done1) begin
            if (done0 && done1) ob.overlap = 1'b1;
            ob.timeout = 1'b0;
            ob.port    = done1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({gnt0, gnt1, done0, done1, mem_en, mem_we, busy} !== 7'b0) begin
         n_err++; $display("FAIL reset_ctrl: got %b want 0000000", {gnt0, gnt1, done0, done1, mem_en, mem_we, busy});
      end
      n_vec++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         n_err++; $display("FAIL reset_mem_bus: addr %h wdata %h want 0", mem_addr, mem_wdata);
      end
      n_vec++;
      if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
         n_err++; $display("FAIL reset_rdata: %h %h want 0", rdata0, rdata1);
      end
      n_vec++;
      if ({b_busy, b_gnt0, b_gnt1, b_done0, b_done1, b_mem_en} !== 6'b0) begin
         n_err++; $display("FAIL reset_lat1: got %b want 000000", {b_busy, b_gnt0, b_gnt1, b_done0, b_done1, b_mem_en});
      end
   endtask

   task automatic test_single_read();
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
      push_rd(1'b0, 32'h40);
      wait_done(10, o);
      drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
      e = sb.pop_front();
      n_vec++;
      if (o.timeout || o.port !== e.port) begin
         n_err++; $display("FAIL rd_port: got %0d (timeout %0d) want %0d", o.port, o.timeout, e.port);
      end
      n_vec++;
      if (rdata0 !== e.rdata) begin n_err++; $display("FAIL rd_data: got %h want %h", rdata0, e.rdata); end
      n_vec++;
      if (o.en_cnt != LAT || o.addr !== 32'h40 || o.unstable) begin
         n_err++; $display("FAIL rd_mem_en: en %0d addr %h unstable %0d want %0d 00000040 0", o.en_cnt, o.addr, o.unstable, LAT);
      end
      n_vec++;
      if (o.cycles != LAT + 1) begin n_err++; $display("FAIL rd_latency: got %0d want %0d", o.cycles, LAT + 1); end
      n_vec++;
      if (o.g1) begin n_err++; $display("FAIL rd_gnt1: gnt1 seen, want never"); end
      @(negedge clk);
      n_vec++;
      if (done0 !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL rd_pulse: done0 %b busy %b want 0 0", done0, busy);
      end
   endtask

   task automatic test_single_write();
      drive(1'b1, 1'b1, 1'b1, 32'h80, 32'h12345678);
      push_wr(1'b1, 32'h80, 32'h12345678);
      wait_done(10, o);
      drive(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
      e = sb.pop_front();
      n_vec++;
      if (o.timeout || o.port !== e.port) begin
         n_err++; $display("FAIL wr_port: got %0d (timeout %0d) want %0d", o.port, o.timeout, e.port);
      end
      n_vec++;
      if (rdata1 !== e.rdata) begin n_err++; $display("FAIL wr_rdata_hold: got %h want %h", rdata1, e.rdata); end
      n_vec++;
      if (o.en_cnt != LAT || o.we !== 1'b1 || o.addr !== 32'h80 || o.wdata !== 32'h12345678 || o.unstable) begin
         n_err++; $display("FAIL wr_bus: en %0d we %b addr %h wdata %h unstable %0d", o.en_cnt, o.we, o.addr, o.wdata, o.unstable);
      end
      n_vec++;
      if (o.g0) begin n_err++; $display("FAIL wr_gnt0: gnt0 seen, want never"); end
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
      push_rd(1'b0, 32'h80);
      wait_done(10, o);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      e = sb.pop_front();
      n_vec++;
      if (o.timeout || o.port !== e.port || rdata0 !== e.rdata) begin
         n_err++; $display("FAIL wr_readback: port %0d data %h want %0d %h", o.port, rdata0, e.port, e.rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h48, 32'h0);
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) push_rd(1'b0, 32'h44);
         else            push_rd(1'b1, 32'h48);
      end
      for (int k = 0; k < 4; k++) begin
         wait_done(12, o);
         if (k == 3) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         end
         e = sb.pop_front();
         n_vec++;
         if (o.timeout || o.port !== e.port) begin
            n_err++; $display("FAIL b2b_order[%0d]: got %0d (timeout %0d) want %0d", k, o.port, o.timeout, e.port);
         end
         n_vec++;
         if ((e.port ? rdata1 : rdata0) !== e.rdata) begin
            n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k, e.port ? rdata1 : rdata0, e.rdata);
         end
         n_vec++;
         if (o.cycles != ((k == 0) ? LAT + 1 : LAT + 2)) begin
            n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, o.cycles, (k == 0) ? LAT + 1 : LAT + 2);
         end
         n_vec++;
         if (o.overlap) begin n_err++; $display("FAIL b2b_overlap[%0d]: both ports active, want one", k); end
      end
      @(negedge clk);
   endtask

   task automatic test_late_request();
      drive(1'b0, 1'b1, 1'b0, 32'h4C, 32'h0);
      push_rd(1'b0, 32'h4C);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
      push_rd(1'b1, 32'h50);
      wait_done(10, o);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      e = sb.pop_front();
      n_vec++;
      if (o.timeout || o.port !== e.port || rdata0 !== e.rdata || o.cycles != LAT) begin
         n_err++; $display("FAIL late_first: port %0d data %h cycles %0d want %0d %h %0d", o.port, rdata0, o.cycles, e.port, e.rdata, LAT);
      end
      n_vec++;
      if (o.g1) begin n_err++; $display("FAIL late_preempt: gnt1 during port 0 access, want 0"); end
      wait_done(10, o);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      e = sb.pop_front();
      n_vec++;
      if (o.timeout || o.port !== e.port || rdata1 !== e.rdata) begin
         n_err++; $display("FAIL late_second: port %0d data %h want %0d %h", o.port, rdata1, e.port, e.rdata);
      end
      n_vec++;
      if (o.cycles != LAT + 2 || o.g0 || o.overlap) begin
         n_err++; $display("FAIL late_timing: cycles %0d g0 %0d overlap %0d want %0d 0 0", o.cycles, o.g0, o.overlap, LAT + 2);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_access();
      drive(1'b0, 1'b1, 1'b0, 32'h54, 32'h0);
      @(negedge clk);
      n_vec++;
      if (mem_en !== 1'b1) begin n_err++; $display("FAIL mid_access_start: mem_en %b want 1", mem_en); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      last_rd[0] = '0;
      last_rd[1] = '0;
      n_vec++;
      if ({gnt0, gnt1, done0, done1, mem_en, mem_we, busy} !== 7'b0 || mem_addr !== 32'h0 || rdata0 !== 32'h0) begin
         n_err++; $display("FAIL mid_reset_outputs: ctrl %b addr %h rdata0 %h want 0", {gnt0, gnt1, done0, done1, mem_en, mem_we, busy}, mem_addr, rdata0);
      end
      wait_done(6, o);
      n_vec++;
      if (!o.timeout) begin n_err++; $display("FAIL mid_reset_no_done: done seen on port %0d, want none", o.port); end
      drive(1'b0, 1'b1, 1'b0, 32'h58, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h5C, 32'h0);
      push_rd(1'b0, 32'h58);
      push_rd(1'b1, 32'h5C);
      wait_done(10, o);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      e = sb.pop_front();
      n_vec++;
      if (o.timeout || o.port !== e.port || rdata0 !== e.rdata) begin
         n_err++; $display("FAIL mid_reset_tie: port %0d data %h want %0d %h", o.port, rdata0, e.port, e.rdata);
      end
      wait_done(10, o);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      e = sb.pop_front();
      n_vec++;
      if (o.timeout || o.port !== e.port || rdata1 !== e.rdata) begin
         n_err++; $display("FAIL mid_reset_second: port %0d data %h want %0d %h", o.port, rdata1, e.port, e.rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_lat1();
      int en_cnt;
      int done_at;
      en_cnt  = 0;
      done_at = 0;
      b_req0  = 1'b1;
      for (int i = 1; i <= 6 && done_at == 0; i++) begin
         @(negedge clk);
         if (b_mem_en) en_cnt++;
         if (b_done0) begin done_at = i; b_req0 = 1'b0; end
      end
      b_req0 = 1'b0;
      n_vec++;
      if (en_cnt != 1 || done_at != 2) begin
         n_err++; $display("FAIL lat1_timing: en %0d done_at %0d want 1 2", en_cnt, done_at);
      end
      n_vec++;
      if (b_rdata0 !== (32'h10 ^ 32'h5A5A5A5A)) begin
         n_err++; $display("FAIL lat1_data: got %h want %h", b_rdata0, 32'h10 ^ 32'h5A5A5A5A);
      end
      @(negedge clk);
      n_vec++;
      if (b_busy !== 1'b0 || b_done0 !== 1'b0 || b_gnt1 !== 1'b0) begin
         n_err++; $display("FAIL lat1_idle: busy %b done0 %b gnt1 %b want 0 0 0", b_busy, b_done0, b_gnt1);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) exp_mem[i] = init_val(32'(i * 4));
      rst = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      b_req0 = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      @(negedge clk);
      test_reset();
      test_single_read();
      test_single_write();
      test_back_to_back();
      test_late_request();
      test_reset_mid_access();
      test_lat1();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port of the multicycle datapath between two requesters.
  - Port 0 is the CPU datapath, which drives instruction fetch and load/store through the IorD path.
  - Port 1 is a secondary master, such as a DMA or debug loader.
- Grants one fixed-latency memory access at a time using round-robin priority.
- Holds memory control signals stable for the whole access, registers the read data, and signals completion with a one-cycle done pulse per requester.

Parameters:
ADDR_W, 32, width of the address buses
DATA_W, 32, width of the data buses
MEM_LAT, 2, memory access cycles, from first ACCESS cycle to the cycle read data is valid (must be >= 1)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req0  input  1  port 0 request; held until done0
we0  input  1  port 0 write enable (1=store, 0=load)
addr0  input  ADDR_W  port 0 address
wdata0  input  DATA_W  port 0 write data
gnt0  output  1  port 0 owns the memory (ACCESS or DONE)
done0  output  1  one-cycle completion pulse for port 0
rdata0  output  DATA_W  port 0 registered read data
req1  input  1  port 1 request
we1  input  1  port 1 write enable
addr1  input  ADDR_W  port 1 address
wdata1  input  DATA_W  port 1 write data
gnt1  output  1  port 1 owns the memory
done1  output  1  port 1 completion pulse
rdata1  output  DATA_W  port 1 registered read data
mem_en  output  1  memory enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid in the final ACCESS cycle
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values (synchronous, also when asserted mid-access):
  - State=IDLE.
  - gnt0/gnt1/done0/done1/mem_en/mem_we/busy = 0.
  - mem_addr, mem_wdata, rdata0, rdata1 = 0.
  - Round-robin pointer last=1, so port 0 wins the first tie.
  - Any in-flight access is abandoned; no done pulse is produced.
- State machine IDLE -> ACCESS -> DONE -> IDLE. State is registered; all outputs are registered or decoded from registered state only.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != last.
  - On grant: latch sel, addr, wdata and we into internal registers; set last=sel; cnt=MEM_LAT-1; go to ACCESS.
- ACCESS:
  - mem_en=1; mem_we=latched we.
  - mem_addr and mem_wdata come from the latched values, stable for all MEM_LAT cycles.
  - Requester inputs are ignored while in ACCESS.
  - Each cycle with cnt != 0, decrement cnt.
  - When cnt==0: if it is a read, capture mem_rdata into rdata[sel] (a write leaves rdata[sel] unchanged); go to DONE.
- DONE:
  - mem_en=0, mem_we=0.
  - done[sel]=1 for exactly this cycle; gnt[sel] stays high.
  - Next state is IDLE.
- Timing:
  - gnt[sel] = (state==ACCESS or DONE) and sel matches.
  - The other port's gnt/done stay 0 throughout.
  - Latency: req sampled high at rising edge E (state IDLE) -> ACCESS during cycles E..E+MEM_LAT-1 -> done pulses in cycle E+MEM_LAT.
  - One transaction occupies MEM_LAT+2 cycles, including the IDLE re-arbitration cycle.
- rdata hold: rdataN holds its value until the next read completes for port N.
- Requester rules:
  - Hold req/we/addr/wdata stable until done.
  - Drop req in the cycle after done if no further access is wanted. A req still high in the IDLE cycle after DONE is treated as a new request.
  - If req drops mid-access, the access still completes and done still pulses.
- Fairness: with both reqs held continuously, grants alternate 0,1,0,1...; neither port waits more than one transaction.
- Arbitration happens only in IDLE. A request arriving during ACCESS/DONE waits and does not pre-empt the current access.

Test Plan:
- Single read: MEM_LAT=2; memory returns 0xDEADBEEF for addr 0x40; pulse req0 with we0=0 -> mem_en high for exactly 2 cycles with mem_addr=0x40; done0 in the following cycle; rdata0=0xDEADBEEF; gnt1/done1 stay 0.
- Single write: req1, we1=1, addr1=0x80, wdata1=0x12345678 -> mem_we=1 with stable addr/data for 2 cycles; done1 pulses once; rdata1 unchanged; readback through port 0 returns 0x12345678.
- Simultaneous requests after reset: req0 and req1 rise in the same cycle and are held -> grant order 0,1,0,1 over 4 transactions; each done spaced 4 cycles (MEM_LAT+2) apart.
- Late request: req1 asserted while port 0 is in ACCESS -> port 0 completes undisturbed; port 1 is granted in the next IDLE cycle; no overlap of gnt0/gnt1.
- Reset mid-access: assert rst during the 2nd ACCESS cycle -> next cycle all outputs 0, state IDLE, no done pulse; after reset a tie grants port 0.
- MEM_LAT=1 build: single read -> mem_en high for 1 cycle, done on the next cycle; total 3 cycles per transaction.
